// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer execution unit between the RS and the CDB.
// S1 registers the issued operation, S2 registers the computed result and acts as
// the skid buffer while the CDB arbiter back-pressures.
// Optional feature macro: ALU_MUL_EN adds MUL/MULH/MULHSU/MULHU with a one-cycle
// S1 stall; without it the multiply opcodes decode as undefined.
// Opcode encodings below are a local copy of the shared opcode table; keep in sync.
module alu_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ROB_W = 6,
    parameter int unsigned OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_lhs,
    input  logic [XLEN-1:0]  in_rhs,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ROB_W-1:0] in_rob,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROB_W-1:0] out_rob,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_pc_init,
    output logic [XLEN-1:0]  out_pc
);

    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_XOR    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR     = OP_W'(4);
    localparam logic [OP_W-1:0] OP_AND    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLL    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL    = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLT    = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_XORI   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ORI    = OP_W'(13);
    localparam logic [OP_W-1:0] OP_ANDI   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_SLLI   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SRLI   = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SRAI   = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SLTI   = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SLTIU  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_BEQ    = OP_W'(20);
    localparam logic [OP_W-1:0] OP_BNE    = OP_W'(21);
    localparam logic [OP_W-1:0] OP_BLT    = OP_W'(22);
    localparam logic [OP_W-1:0] OP_BGE    = OP_W'(23);
    localparam logic [OP_W-1:0] OP_BLTU   = OP_W'(24);
    localparam logic [OP_W-1:0] OP_BGEU   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_JAL    = OP_W'(26);
    localparam logic [OP_W-1:0] OP_JALR   = OP_W'(27);
`ifdef ALU_MUL_EN
    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(28);
    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(29);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(30);
    localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(31);
`endif

    // S1 operand register
    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q, s1_op_d;
    logic [XLEN-1:0]  s1_lhs_q, s1_lhs_d;
    logic [XLEN-1:0]  s1_rhs_q, s1_rhs_d;
    logic [XLEN-1:0]  s1_imm_q, s1_imm_d;
    logic [XLEN-1:0]  s1_pc_q, s1_pc_d;
    logic [ROB_W-1:0] s1_rob_q, s1_rob_d;

    // S2 result register / skid buffer
    logic             out_valid_q, out_valid_d;
    logic [ROB_W-1:0] out_rob_q, out_rob_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [XLEN-1:0]  out_pc_init_q, out_pc_init_d;
    logic [XLEN-1:0]  out_pc_q, out_pc_d;

    logic            s1_done;
    logic            s2_free;
    logic            accept;
    logic            advance;
    logic            take;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] alu_npc;

`ifdef ALU_MUL_EN
    logic                mul_cnt_q, mul_cnt_d;
    logic                s1_is_mul;
    logic signed [XLEN:0] mul_a;
    logic signed [XLEN:0] mul_b;
    logic [2*XLEN-1:0]   mul_p;

    // Multiply decode and a single wide signed product covering all four forms
    always_comb begin
        s1_is_mul = (s1_op_q == OP_MUL) || (s1_op_q == OP_MULH) ||
                    (s1_op_q == OP_MULHSU) || (s1_op_q == OP_MULHU);
        mul_a = {((s1_op_q == OP_MULH) || (s1_op_q == OP_MULHSU)) & s1_lhs_q[XLEN-1], s1_lhs_q};
        mul_b = {(s1_op_q == OP_MULH) & s1_rhs_q[XLEN-1], s1_rhs_q};
        mul_p = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
        // A multiply spends its first S1 cycle with s1_done low
        s1_done = !(s1_is_mul && !mul_cnt_q);
    end
`else
    // No multi-cycle ops: S1 is always ready to hand over
    always_comb begin
        s1_done = 1'b1;
    end
`endif

    // Handshake terms; in_ready is combinational and independent of in_valid
    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || (s1_done && s2_free);
        accept   = rdy && in_valid && in_ready && !flush;
        advance  = s1_valid_q && s1_done && s2_free && rdy;
        take     = out_valid_q && out_ready && rdy;
    end

    // Execute: result and resolved next pc from the S1 operands
    always_comb begin
        logic [SHW-1:0]  sh_r;
        logic [SHW-1:0]  sh_i;
        logic [XLEN-1:0] pc_plus4;
        logic            is_br;
        logic            br_take;

        sh_r     = s1_rhs_q[SHW-1:0];
        sh_i     = s1_imm_q[SHW-1:0];
        pc_plus4 = s1_pc_q + XLEN'(4);
        is_br    = 1'b0;
        br_take  = 1'b0;
        alu_res  = '0;
        alu_npc  = pc_plus4;

        case (s1_op_q)
            OP_ADD:   alu_res = s1_lhs_q + s1_rhs_q;
            OP_SUB:   alu_res = s1_lhs_q - s1_rhs_q;
            OP_XOR:   alu_res = s1_lhs_q ^ s1_rhs_q;
            OP_OR:    alu_res = s1_lhs_q | s1_rhs_q;
            OP_AND:   alu_res = s1_lhs_q & s1_rhs_q;
            OP_SLL:   alu_res = s1_lhs_q << sh_r;
            OP_SRL:   alu_res = s1_lhs_q >> sh_r;
            OP_SRA:   alu_res = $signed(s1_lhs_q) >>> sh_r;
            OP_SLT:   alu_res = XLEN'($signed(s1_lhs_q) < $signed(s1_rhs_q));
            OP_SLTU:  alu_res = XLEN'(s1_lhs_q < s1_rhs_q);
            OP_ADDI:  alu_res = s1_lhs_q + s1_imm_q;
            OP_XORI:  alu_res = s1_lhs_q ^ s1_imm_q;
            OP_ORI:   alu_res = s1_lhs_q | s1_imm_q;
            OP_ANDI:  alu_res = s1_lhs_q & s1_imm_q;
            OP_SLLI:  alu_res = s1_lhs_q << sh_i;
            OP_SRLI:  alu_res = s1_lhs_q >> sh_i;
            OP_SRAI:  alu_res = $signed(s1_lhs_q) >>> sh_i;
            OP_SLTI:  alu_res = XLEN'($signed(s1_lhs_q) < $signed(s1_imm_q));
            OP_SLTIU: alu_res = XLEN'(s1_lhs_q < s1_imm_q);
            OP_BEQ:   begin is_br = 1'b1; br_take = (s1_lhs_q == s1_rhs_q); end
            OP_BNE:   begin is_br = 1'b1; br_take = (s1_lhs_q != s1_rhs_q); end
            OP_BLT:   begin is_br = 1'b1; br_take = ($signed(s1_lhs_q) < $signed(s1_rhs_q)); end
            OP_BGE:   begin is_br = 1'b1; br_take = ($signed(s1_lhs_q) >= $signed(s1_rhs_q)); end
            OP_BLTU:  begin is_br = 1'b1; br_take = (s1_lhs_q < s1_rhs_q); end
            OP_BGEU:  begin is_br = 1'b1; br_take = (s1_lhs_q >= s1_rhs_q); end
            OP_JAL: begin
                alu_res = pc_plus4;
                alu_npc = s1_imm_q;
            end
            OP_JALR: begin
                alu_res = pc_plus4;
                alu_npc = (s1_lhs_q + s1_imm_q) & ~XLEN'(1);
            end
`ifdef ALU_MUL_EN
            OP_MUL:    alu_res = mul_p[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  alu_res = mul_p[2*XLEN-1:XLEN];
`endif
            // Undefined ops still complete so the ROB entry retires
            default: begin
                alu_res = '0;
                alu_npc = '0;
            end
        endcase

        if (is_br) begin
            alu_res = XLEN'(br_take);
            alu_npc = br_take ? (s1_pc_q + s1_imm_q) : pc_plus4;
        end
    end

    // Next-state: flush clears valids, rdy gates every other update
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_op_d       = s1_op_q;
        s1_lhs_d      = s1_lhs_q;
        s1_rhs_d      = s1_rhs_q;
        s1_imm_d      = s1_imm_q;
        s1_pc_d       = s1_pc_q;
        s1_rob_d      = s1_rob_q;
        out_valid_d   = out_valid_q;
        out_rob_d     = out_rob_q;
        out_result_d  = out_result_q;
        out_pc_init_d = out_pc_init_q;
        out_pc_d      = out_pc_q;
`ifdef ALU_MUL_EN
        mul_cnt_d     = mul_cnt_q;
`endif

        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
            mul_cnt_d   = 1'b0;
`endif
        end else if (rdy) begin
            if (accept) begin
                s1_valid_d = 1'b1;
                s1_op_d    = in_op;
                s1_lhs_d   = in_lhs;
                s1_rhs_d   = in_rhs;
                s1_imm_d   = in_imm;
                s1_pc_d    = in_pc;
                s1_rob_d   = in_rob;
            end else if (advance) begin
                s1_valid_d = 1'b0;
            end

            if (advance) begin
                out_valid_d   = 1'b1;
                out_rob_d     = s1_rob_q;
                out_result_d  = alu_res;
                out_pc_init_d = s1_pc_q;
                out_pc_d      = alu_npc;
            end else if (take) begin
                out_valid_d = 1'b0;
            end

`ifdef ALU_MUL_EN
            if (advance) begin
                mul_cnt_d = 1'b0;
            end else if (s1_valid_q && s1_is_mul && !mul_cnt_q) begin
                mul_cnt_d = 1'b1;
            end
`endif
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_op_q       <= '0;
            s1_lhs_q      <= '0;
            s1_rhs_q      <= '0;
            s1_imm_q      <= '0;
            s1_pc_q       <= '0;
            s1_rob_q      <= '0;
            out_valid_q   <= 1'b0;
            out_rob_q     <= '0;
            out_result_q  <= '0;
            out_pc_init_q <= '0;
            out_pc_q      <= '0;
`ifdef ALU_MUL_EN
            mul_cnt_q     <= 1'b0;
`endif
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_op_q       <= s1_op_d;
            s1_lhs_q      <= s1_lhs_d;
            s1_rhs_q      <= s1_rhs_d;
            s1_imm_q      <= s1_imm_d;
            s1_pc_q       <= s1_pc_d;
            s1_rob_q      <= s1_rob_d;
            out_valid_q   <= out_valid_d;
            out_rob_q     <= out_rob_d;
            out_result_q  <= out_result_d;
            out_pc_init_q <= out_pc_init_d;
            out_pc_q      <= out_pc_d;
`ifdef ALU_MUL_EN
            mul_cnt_q     <= mul_cnt_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rob     = out_rob_q;
    assign out_result  = out_result_q;
    assign out_pc_init = out_pc_init_q;
    assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed stimulus with a scoreboard for alu_pipe (XLEN=32).
// Define ALU_MUL_EN for both bench and RTL to cover the multiply build.
module tb_alu_pipe;

    localparam logic [5:0] OP_ADD = 6'd1,   OP_SUB = 6'd2,   OP_XOR = 6'd3,   OP_OR = 6'd4;
    localparam logic [5:0] OP_AND = 6'd5,   OP_SLL = 6'd6,   OP_SRL = 6'd7,   OP_SRA = 6'd8;
    localparam logic [5:0] OP_SLT = 6'd9,   OP_SLTU = 6'd10, OP_ADDI = 6'd11, OP_XORI = 6'd12;
    localparam logic [5:0] OP_ORI = 6'd13,  OP_ANDI = 6'd14, OP_SLLI = 6'd15, OP_SRLI = 6'd16;
    localparam logic [5:0] OP_SRAI = 6'd17, OP_SLTI = 6'd18, OP_SLTIU = 6'd19;
    localparam logic [5:0] OP_BEQ = 6'd20,  OP_BNE = 6'd21,  OP_BLT = 6'd22,  OP_BGE = 6'd23;
    localparam logic [5:0] OP_BLTU = 6'd24, OP_BGEU = 6'd25, OP_JAL = 6'd26,  OP_JALR = 6'd27;
    localparam logic [5:0] OP_MUL = 6'd28,  OP_MULH = 6'd29, OP_MULHSU = 6'd30, OP_MULHU = 6'd31;
    localparam logic [5:0] OP_UNDEF = 6'd63;

    typedef struct packed {
        logic [5:0]  rob;
        logic [31:0] res;
        logic [31:0] pci;
        logic [31:0] npc;
    } exp_t;

    logic        clk, rst, rdy, flush;
    logic        in_valid, in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_lhs, in_rhs, in_imm, in_pc;
    logic [5:0]  in_rob;
    logic        out_valid, out_ready;
    logic [5:0]  out_rob;
    logic [31:0] out_result, out_pc_init, out_pc;

    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];

    alu_pipe #(.XLEN(32), .ROB_W(6), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_lhs(in_lhs), .in_rhs(in_rhs), .in_imm(in_imm), .in_pc(in_pc), .in_rob(in_rob),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob),
        .out_result(out_result), .out_pc_init(out_pc_init), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one operation
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] pc, input logic [5:0] rob);
        exp_t m;
        logic [63:0] p;
        logic br, t;
        m.rob = rob; m.pci = pc; m.res = 32'd0; m.npc = pc + 32'd4;
        br = 1'b0; t = 1'b0; p = 64'd0;
        case (op)
            OP_ADD:   m.res = a + b;
            OP_SUB:   m.res = a - b;
            OP_XOR:   m.res = a ^ b;
            OP_OR:    m.res = a | b;
            OP_AND:   m.res = a & b;
            OP_SLL:   m.res = a << b[4:0];
            OP_SRL:   m.res = a >> b[4:0];
            OP_SRA:   m.res = $signed(a) >>> b[4:0];
            OP_SLT:   m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  m.res = (a < b) ? 32'd1 : 32'd0;
            OP_ADDI:  m.res = a + imm;
            OP_XORI:  m.res = a ^ imm;
            OP_ORI:   m.res = a | imm;
            OP_ANDI:  m.res = a & imm;
            OP_SLLI:  m.res = a << imm[4:0];
            OP_SRLI:  m.res = a >> imm[4:0];
            OP_SRAI:  m.res = $signed(a) >>> imm[4:0];
            OP_SLTI:  m.res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: m.res = (a < imm) ? 32'd1 : 32'd0;
            OP_BEQ:   begin br = 1'b1; t = (a == b); end
            OP_BNE:   begin br = 1'b1; t = (a != b); end
            OP_BLT:   begin br = 1'b1; t = ($signed(a) < $signed(b)); end
            OP_BGE:   begin br = 1'b1; t = ($signed(a) >= $signed(b)); end
            OP_BLTU:  begin br = 1'b1; t = (a < b); end
            OP_BGEU:  begin br = 1'b1; t = (a >= b); end
            OP_JAL:   begin m.res = pc + 32'd4; m.npc = imm; end
            OP_JALR:  begin m.res = pc + 32'd4; m.npc = (a + imm) & 32'hFFFF_FFFE; end
`ifdef ALU_MUL_EN
            OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; m.res = p[31:0]; end
            OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; m.res = p[63:32]; end
            OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; m.res = p[63:32]; end
            OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; m.res = p[63:32]; end
`endif
            default:  begin m.res = 32'd0; m.npc = 32'd0; end
        endcase
        if (br) begin
            m.res = t ? 32'd1 : 32'd0;
            m.npc = t ? (pc + imm) : (pc + 32'd4);
        end
        return m;
    endfunction

    // Scoreboard: pop/compare on each CDB transfer, push on each accepted issue
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (flush) begin
                sbq.delete();
            end else if (rdy) begin
                if (out_valid && out_ready) begin
                    tests++;
                    assert (sbq.size() != 0) else begin
                        fails++;
                        $error("FAIL unexpected_result: observed rob=%0d result=0x%0h expected=none", out_rob, out_result);
                    end
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check("sb_rob", 64'(out_rob), 64'(e.rob));
                        check("sb_result", 64'(out_result), 64'(e.res));
                        check("sb_pc_init", 64'(out_pc_init), 64'(e.pci));
                        check("sb_pc", 64'(out_pc), 64'(e.npc));
                    end
                end
                if (in_valid && in_ready)
                    sbq.push_back(model(in_op, in_lhs, in_rhs, in_imm, in_pc, in_rob));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [5:0] rob);
        in_valid = 1'b1; in_op = op; in_lhs = a; in_rhs = b; in_imm = imm; in_pc = pc; in_rob = rob;
    endtask

    // Offer one op and wait (bounded) until it is accepted
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [5:0] rob);
        logic acc;
        acc = 1'b0;
        set_op(op, a, b, imm, pc, rob);
        for (int k = 0; k < 8 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready && rdy && !flush;
            tick();
        end
        check("issue_accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    logic [5:0]  hold_rob;
    logic [31:0] hold_res, hold_pc;

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_op = '0; in_lhs = '0; in_rhs = '0; in_imm = '0; in_pc = '0; in_rob = '0;
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_rob", 64'(out_rob), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_pc_init", 64'(out_pc_init), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // ADDI latency: accepted at edge N, visible after edge N+1
        set_op(OP_ADDI, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'h100, 6'd7);
        tick();
        in_valid = 1'b0;
        check("addi_not_yet", 64'(out_valid), 64'd0);
        tick();
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_result", 64'(out_result), 64'd2);
        check("addi_pc", 64'(out_pc), 64'h104);
        check("addi_rob", 64'(out_rob), 64'd7);
        tick();
        check("addi_drained", 64'(out_valid), 64'd0);

        // Back-to-back stream at full rate
        set_op(OP_SUB, 32'd10, 32'd3, 32'd0, 32'h10, 6'd1);
        tick();
        check("stream_ready0", 64'(in_ready), 64'd1);
        set_op(OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'h14, 6'd2);
        tick();
        check("stream_ready1", 64'(in_ready), 64'd1);
        check("stream_sub", 64'(out_result), 64'd7);
        set_op(OP_SLTIU, 32'd1, 32'd0, 32'd2, 32'h18, 6'd3);
        tick();
        in_valid = 1'b0;
        check("stream_sra", 64'(out_result), 64'hF800_0000);
        tick();
        check("stream_valid", 64'(out_valid), 64'd1);
        check("stream_sltiu", 64'(out_result), 64'd1);
        tick();

        // Branch and jump resolution
        issue(OP_BNE, 32'd1, 32'd2, 32'h40, 32'h200, 6'd4);
        issue(OP_JALR, 32'h301, 32'd0, 32'd2, 32'h300, 6'd5);
        check("bne_result", 64'(out_result), 64'd1);
        check("bne_pc", 64'(out_pc), 64'h240);
        tick();
        check("jalr_result", 64'(out_result), 64'h304);
        check("jalr_pc", 64'(out_pc), 64'h302);

        // Wider opcode mix through the scoreboard
        issue(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'h20, 6'd10);
        issue(OP_SLL, 32'h0000_0001, 32'd31, 32'd0, 32'h24, 6'd11);
        issue(OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'd0, 32'h28, 6'd12);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h2C, 6'd13);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h30, 6'd14);
        issue(OP_SRAI, 32'h8000_0010, 32'd0, 32'd36, 32'h34, 6'd15);
        issue(OP_SLTI, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'h38, 6'd16);
        issue(OP_ANDI, 32'h1234_5678, 32'd0, 32'hFFFF_FF00, 32'h3C, 6'd17);
        issue(OP_BEQ, 32'd3, 32'd4, 32'h80, 32'h40, 6'd18);
        issue(OP_BLT, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF0, 32'h44, 6'd19);
        issue(OP_BGEU, 32'hFFFF_FFFF, 32'd0, 32'h10, 32'h48, 6'd20);
        issue(OP_JAL, 32'd0, 32'd0, 32'h1000, 32'h4C, 6'd21);
        issue(OP_UNDEF, 32'd9, 32'd9, 32'd9, 32'h50, 6'd22);
        issue(OP_MUL, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'h54, 6'd23);
        issue(OP_MULH, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'h58, 6'd24);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h5C, 6'd25);
        tick(); tick(); tick(); tick();
        check("mix_drained", 64'(sbq.size()), 64'd0);

        // Back-pressure: S2 and S1 hold, third op is refused until release
        out_ready = 1'b0;
        set_op(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h60, 6'd30);
        tick();
        set_op(OP_ADD, 32'd2, 32'd2, 32'd0, 32'h64, 6'd31);
        check("bp_ready_s1free", 64'(in_ready), 64'd1);
        tick();
        set_op(OP_ADD, 32'd3, 32'd3, 32'd0, 32'h68, 6'd32);
        check("bp_ready_full", 64'(in_ready), 64'd0);
        tick();
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_rob", 64'(out_rob), 64'd30);
        hold_rob = out_rob; hold_res = out_result; hold_pc = out_pc;
        tick();
        check("bp_stable_rob", 64'(out_rob), 64'(hold_rob));
        check("bp_stable_res", 64'(out_result), 64'(hold_res));
        check("bp_stable_pc", 64'(out_pc), 64'(hold_pc));
        check("bp_still_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_reload_valid", 64'(out_valid), 64'd1);
        check("bp_reload_rob", 64'(out_rob), 64'd31);
        tick(); tick(); tick();
        check("bp_drained", 64'(sbq.size()), 64'd0);

        // Flush with both stages full and a new op offered
        out_ready = 1'b0;
        set_op(OP_ADD, 32'd5, 32'd5, 32'd0, 32'h70, 6'd40);
        tick();
        set_op(OP_ADD, 32'd6, 32'd6, 32'd0, 32'h74, 6'd41);
        tick();
        set_op(OP_ADD, 32'd7, 32'd7, 32'd0, 32'h78, 6'd42);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        check("flush_gone1", 64'(out_valid), 64'd0);
        tick();
        check("flush_gone2", 64'(out_valid), 64'd0);

        // rdy low for three cycles mid-stream freezes everything
        set_op(OP_OR, 32'hA0, 32'h0B, 32'd0, 32'h80, 6'd50);
        tick();
        set_op(OP_XORI, 32'hFF, 32'd0, 32'h0F, 32'h84, 6'd51);
        tick();
        set_op(OP_SRLI, 32'hF000_0000, 32'd0, 32'd8, 32'h88, 6'd52);
        rdy = 1'b0;
        hold_rob = out_rob; hold_res = out_result; hold_pc = out_pc;
        check("rdy_pre_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_frz_valid", 64'(out_valid), 64'd1);
            check("rdy_frz_rob", 64'(out_rob), 64'(hold_rob));
            check("rdy_frz_res", 64'(out_result), 64'(hold_res));
            check("rdy_frz_pc", 64'(out_pc), 64'(hold_pc));
        end
        rdy = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("rdy_drained", 64'(sbq.size()), 64'd0);

        // Multiply: 3-cycle latency with a stall, or undefined at 2 cycles
        set_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h400, 6'd60);
        tick();
        in_valid = 1'b0;
`ifdef ALU_MUL_EN
        check("mul_stall_ready", 64'(in_ready), 64'd0);
        tick();
        check("mul_not_yet", 64'(out_valid), 64'd0);
        tick();
        check("mul_valid", 64'(out_valid), 64'd1);
        check("mul_result", 64'(out_result), 64'hFFFF_FFFE);
        check("mul_pc", 64'(out_pc), 64'h404);
`else
        check("nomul_not_yet", 64'(out_valid), 64'd0);
        tick();
        check("nomul_valid", 64'(out_valid), 64'd1);
        check("nomul_result", 64'(out_result), 64'd0);
        check("nomul_pc", 64'(out_pc), 64'd0);
`endif
        tick(); tick();
        check("final_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined integer execution unit that replaces the single-cycle combinational ALU between the reservation station (RS) and the common data bus (CDB). It accepts one RS-issued operation per cycle over a valid/ready handshake and registers operands and results. Its output skid register holds a result when the CDB arbiter back-pressures. A flush input discards all in-flight work on misprediction rollback.

## Interface
Parameters:
- XLEN, 32: datapath width (operands, imm, pc, result).
- ROB_W, 6: ROB entry tag width.
- OP_W, 6: opcode width; encodings are the shared `defines.v` opcode macros.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low = all state frozen and no handshakes complete (rst still acts).
- flush  in  1  rollback; synchronously invalidates both stages.
- in_valid  in  1  RS presents an operation.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  OP_W  opcode.
- in_lhs, in_rhs, in_imm, in_pc  in  XLEN each  operands, sign-extended immediate, instruction pc.
- in_rob  in  ROB_W  destination ROB tag.
- out_valid  out  1  result valid to CDB.
- out_ready  in  1  CDB arbiter takes result.
- out_rob  out  ROB_W  tag of result.
- out_result  out  XLEN  writeback value; for branches 1 = taken, 0 = not taken.
- out_pc_init  out  XLEN  instruction pc.
- out_pc  out  XLEN  resolved next pc.

## Operation
- Stage S1 (operand register): holds op, lhs, rhs, imm, pc, rob, and s1_valid.
- Stage S2 (result register, doubles as skid buffer): holds computed result fields and out_valid.
- Accept = rdy & in_valid & in_ready & !flush.
- s2_free = !out_valid | out_ready.
- S1 advances into S2 when s1_valid & s1_done & s2_free & rdy. s1_done is 1 except during multiply (see Configuration).
- in_ready = !s1_valid | (s1_done & s2_free). It is combinational and never depends on in_valid.
- Arithmetic (XLEN-wide, wrap modulo 2^XLEN):
  - ADD/ADDI/SUB, XOR/OR/AND and their immediate forms.
  - Shift amount is rhs[log2(XLEN)-1:0] for register forms and imm[log2(XLEN)-1:0] for immediate forms.
  - SRL/SRLI are logical; SRA/SRAI are arithmetic.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. SLTIU uses imm.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU: taken gives result=1 and out_pc=pc+imm; not-taken gives result=0 and out_pc=pc+4.
- JAL: result=pc+4, out_pc=imm. JALR: result=pc+4, out_pc=(lhs+imm)&~1.
- All other ALU ops: out_pc=pc+4. out_pc_init=pc always.
- Undefined opcode: result=0, out_pc=0, and the op still completes with its tag, so the ROB is never starved.
- Flush: s1_valid, out_valid, and the multiply counter are cleared next edge. An op offered in the flush cycle is not accepted. Data registers need not clear.
- rst: all registers, including data outputs, go to 0.

## Timing
- Reset values: out_valid=0, out_rob=0, out_result=0, out_pc_init=0, out_pc=0. in_ready=1 after reset.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+1. It is visible in cycle N+1 and transfers on the first edge where out_ready & rdy.
- Throughput: 1 op/cycle with out_ready held high.
- Back-pressure: out_valid and all out_* fields stay stable until taken. S1 can still fill, holding one more op; then in_ready=0. No op is lost or duplicated.
- Simultaneous out take and S1 advance in one cycle: S2 reloads with the new result and out_valid stays 1.
- rdy=0: no state change, and out_* are held. Precedence is rst > flush > normal.

## Configuration
- ALU_MUL_EN defined:
  - Adds MUL, MULH, MULHSU, MULHU (opcodes from `defines.v`), with out_pc=pc+4.
  - A multiply in S1 takes one extra cycle: a 1-bit counter holds s1_done=0 for the first S1 cycle.
  - Multiply latency is 3 cycles from accept; throughput is 1 multiply per 2 cycles.
- ALU_MUL_EN undefined: multiply opcodes decode as undefined (result=0, out_pc=0, latency 2). No multiplier logic is present.

## Test plan
- Reset then ADDI lhs=5, imm=-3, rob=7, pc=0x100: out_valid two cycles later with result=2, out_pc=0x104, out_rob=7; all outputs 0 before.
- Stream SUB, SRA(lhs=0x80000000, rhs=4), SLTIU(lhs=1, imm=2), one per cycle with out_ready=1: results 0x?..., 0xF8000000, 1 on consecutive cycles, and in_ready stays 1.
- BNE pc=0x200, lhs≠rhs, imm=0x40 → result=1, out_pc=0x240. JALR lhs=0x301, imm=2 → result=pc+4, out_pc=0x302.
- Hold out_ready=0 with 3 ops offered: two held (one in S2, one in S1) and in_ready=0. Release: results emerge in order with no loss or duplication.
- Assert flush with both stages full and in_valid=1: next cycle out_valid=0 and in_ready=1, and the flushed ops never appear. rdy=0 for 3 cycles mid-stream freezes all outputs.
- With ALU_MUL_EN: MULHU 0xFFFFFFFF×0xFFFFFFFF yields 0xFFFFFFFE at 3-cycle latency, and in_ready=0 for the stall cycle. Without the macro: result=0, out_pc=0, at 2-cycle latency.
